// File: rtl/slave_mem_responder.sv
// Memory-backed slave for the crossbar: registered IDLE/WAIT/ACK handshake,
// fixed or LFSR-driven wait states, and saturating read/write counters.
module slave_mem_responder #(
    parameter int         MEM_DEPTH   = 16,
    parameter int         WAIT_CYCLES = 1,
    parameter bit         RANDOM_WAIT = 1'b0,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slave_req,
    input  logic [31:0] slave_addr,
    input  logic        slave_cmd,
    input  logic [31:0] slave_wdata,
    output logic        slave_ack,
    output logic [31:0] slave_rdata,
    output logic        busy,
    output logic [15:0] wr_cnt,
    output logic [15:0] rd_cnt
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_wcnt;
    logic [3:0]    w_wcnt_nxt;
    logic [3:0]    w_wait;
    logic          w_latch;
    logic          w_done;
    logic [AW-1:0] r_idx;
    logic          r_cmd;
    logic [31:0]   r_wdata;
    logic [7:0]    r_lfsr;
    logic [7:0]    w_lfsr_nxt;
    logic [31:0]   r_mem [MEM_DEPTH];
    logic [31:0]   r_rdata;
    logic [15:0]   r_wr_cnt;
    logic [15:0]   r_rd_cnt;
    logic          w_unused_addr;

    // Upper and byte-lane address bits alias by design.
    assign w_unused_addr = ^{slave_addr[31:AW+2], slave_addr[1:0]};

    assign w_lfsr_nxt = {r_lfsr[6:0],
                         r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_wait = RANDOM_WAIT ? {2'b00, r_lfsr[1:0]}
                                : 4'(WAIT_CYCLES);

    always_comb begin
        w_next     = r_state;
        w_wcnt_nxt = r_wcnt;
        w_latch    = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (slave_req) begin
                    w_latch = 1'b1;
                    if (w_wait == 4'd0) begin
                        w_next = S_ACK;
                    end else begin
                        w_next     = S_WAIT;
                        w_wcnt_nxt = w_wait - 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (!slave_req) begin
                    w_next = S_IDLE;
                end else if (r_wcnt == 4'd0) begin
                    w_next = S_ACK;
                end else begin
                    w_wcnt_nxt = r_wcnt - 4'd1;
                end
            end
            S_ACK: begin
                w_next = S_IDLE;
                w_done = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_wcnt   <= 4'd0;
            r_idx    <= '0;
            r_cmd    <= 1'b0;
            r_wdata  <= 32'd0;
            r_lfsr   <= LFSR_SEED;
            r_rdata  <= 32'd0;
            r_wr_cnt <= 16'd0;
            r_rd_cnt <= 16'd0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_nxt;
            r_lfsr  <= w_lfsr_nxt;
            if (w_latch) begin
                r_idx   <= slave_addr[AW+1:2];
                r_cmd   <= slave_cmd;
                r_wdata <= slave_wdata;
            end
            if (w_done && !r_cmd) begin
                r_rdata <= r_mem[r_idx];
            end
            if (w_done && r_cmd && r_wr_cnt != 16'hFFFF) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (w_done && !r_cmd && r_rd_cnt != 16'hFFFF) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_done && r_cmd) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign slave_ack   = (r_state == S_ACK);
    assign busy        = (r_state != S_IDLE);
    assign slave_rdata = r_rdata;
    assign wr_cnt      = r_wr_cnt;
    assign rd_cnt      = r_rd_cnt;

endmodule

// File: tb/tb_slave_mem_responder.sv
// Directed and LFSR-model checks of slave_mem_responder across three
// configurations: fixed wait 1, fixed wait 3, and random wait.
module tb_slave_mem_responder;
    logic        clk;
    logic        rst   [3];
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        cmd   [3];
    logic [31:0] wdata [3];
    logic        ack   [3];
    logic [31:0] rdata [3];
    logic        bsy   [3];
    logic [15:0] wrc   [3];
    logic [15:0] rdc   [3];

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_lfsr;
    logic [31:0] m_mem [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    slave_mem_responder #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(rst[0]), .slave_req(req[0]),
        .slave_addr(addr[0]), .slave_cmd(cmd[0]),
        .slave_wdata(wdata[0]), .slave_ack(ack[0]),
        .slave_rdata(rdata[0]), .busy(bsy[0]),
        .wr_cnt(wrc[0]), .rd_cnt(rdc[0]));

    slave_mem_responder #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(rst[1]), .slave_req(req[1]),
        .slave_addr(addr[1]), .slave_cmd(cmd[1]),
        .slave_wdata(wdata[1]), .slave_ack(ack[1]),
        .slave_rdata(rdata[1]), .busy(bsy[1]),
        .wr_cnt(wrc[1]), .rd_cnt(rdc[1]));

    slave_mem_responder #(.RANDOM_WAIT(1'b1),
                          .LFSR_SEED(8'hA5)) u_rnd (
        .clk(clk), .reset(rst[2]), .slave_req(req[2]),
        .slave_addr(addr[2]), .slave_cmd(cmd[2]),
        .slave_wdata(wdata[2]), .slave_ack(ack[2]),
        .slave_rdata(rdata[2]), .busy(bsy[2]),
        .wr_cnt(wrc[2]), .rd_cnt(rdc[2]));

    // Independent LFSR reference: x^8+x^6+x^5+x^4+1, shift left.
    always @(posedge clk) begin
        if (rst[2]) m_lfsr <= 8'hA5;
        else m_lfsr <= {m_lfsr[6:0],
                        m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    typedef struct {
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wr;
        int          rd;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    // One transaction; inputs are scrambled once ack is seen so any
    // use of live inputs after acceptance shows up as wrong data.
    task automatic txn(input int k, input logic c, input logic [31:0] a,
                       input logic [31:0] d, output int dly,
                       output logic [7:0] lf);
        bit seen;
        @(negedge clk);
        req[k] = 1'b1; cmd[k] = c; addr[k] = a; wdata[k] = d;
        lf = m_lfsr;
        dly = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            dly++;
            if (ack[k]) seen = 1;
        end
        chk("ack_timeout", {31'd0, seen}, 32'd1);
        req[k] = 1'b0; cmd[k] = ~c; addr[k] = ~a; wdata[k] = ~d;
        @(posedge clk); #1;
        chk("ack_one_cycle", {31'd0, ack[k]}, 32'd0);
    endtask

    initial begin
        int dly;
        int nrd;
        logic [7:0] lf;
        logic [31:0] a, d;
        logic c;
        bit seen;

        tv[0] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0,           1, 0};
        tv[1] = '{1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, 1, 1};
        tv[2] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h1234_5678, 2, 1};
        tv[3] = '{1'b0, 32'h0000_0044, 32'h0,         32'hDEAD_BEEF, 2, 2};
        tv[4] = '{1'b0, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 2, 3};
        tv[5] = '{1'b1, 32'h0000_003F, 32'hA5A5_0001, 32'hDEAD_BEEF, 3, 3};
        tv[6] = '{1'b0, 32'h0000_003C, 32'h0,         32'hA5A5_0001, 3, 4};
        tv[7] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,           3, 5};
        tv[8] = '{1'b1, 32'h0000_0007, 32'h0BAD_F00D, 32'h0,           4, 5};
        tv[9] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0BAD_F00D, 4, 6};

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; cmd[k] = 1'b0;
            addr[k] = 32'd0; wdata[k] = 32'd0;
        end
        for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        chk("rst_ack", {31'd0, ack[0]}, 32'd0);
        chk("rst_busy", {31'd0, bsy[0]}, 32'd0);
        chk("rst_rdata", rdata[0], 32'd0);
        chk("rst_wrcnt", {16'd0, wrc[0]}, 32'd0);
        chk("rst_rdcnt", {16'd0, rdc[0]}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            txn(0, tv[i].cmd, tv[i].addr, tv[i].wdata, dly, lf);
            chk($sformatf("v%0d_delay", i), dly, 32'd2);
            chk($sformatf("v%0d_rdata", i), rdata[0], tv[i].rdata);
            chk($sformatf("v%0d_wrcnt", i), {16'd0, wrc[0]}, tv[i].wr);
            chk($sformatf("v%0d_rdcnt", i), {16'd0, rdc[0]}, tv[i].rd);
            chk($sformatf("v%0d_busy", i), {31'd0, bsy[0]}, 32'd0);
        end

        // Reset lands on the edge that would end ACK of a write.
        @(negedge clk);
        req[0] = 1'b1; cmd[0] = 1'b1;
        addr[0] = 32'd0; wdata[0] = 32'hFFFF_FFFF;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (ack[0]) seen = 1;
        end
        chk("rstack_seen", {31'd0, seen}, 32'd1);
        rst[0] = 1'b1; req[0] = 1'b0;
        @(posedge clk); #1;
        chk("rstack_ack", {31'd0, ack[0]}, 32'd0);
        chk("rstack_wrcnt", {16'd0, wrc[0]}, 32'd0);
        rst[0] = 1'b0;
        txn(0, 1'b0, 32'd0, 32'd0, dly, lf);
        chk("rstack_mem0", rdata[0], 32'd0);
        chk("rstack_wrcnt2", {16'd0, wrc[0]}, 32'd0);
        chk("rstack_rdcnt", {16'd0, rdc[0]}, 32'd1);

        // Wait 3: full write, then a withdrawn write.
        txn(1, 1'b1, 32'd0, 32'h0000_0011, dly, lf);
        chk("w3_delay", dly, 32'd4);
        @(negedge clk);
        req[1] = 1'b1; cmd[1] = 1'b1;
        addr[1] = 32'd0; wdata[1] = 32'h0000_0022;
        @(posedge clk); #1;
        chk("wd_busy_wait", {31'd0, bsy[1]}, 32'd1);
        @(posedge clk); #1;
        chk("wd_noack", {31'd0, ack[1]}, 32'd0);
        req[1] = 1'b0;
        @(posedge clk); #1;
        chk("wd_busy_idle", {31'd0, bsy[1]}, 32'd0);
        chk("wd_wrcnt", {16'd0, wrc[1]}, 32'd1);
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack[1]) seen = 1;
        end
        chk("wd_no_late_ack", {31'd0, seen}, 32'd0);
        txn(1, 1'b0, 32'd0, 32'd0, dly, lf);
        chk("wd_mem", rdata[1], 32'h0000_0011);
        chk("wd_rdcnt", {16'd0, rdc[1]}, 32'd1);
        chk("wd_wrcnt2", {16'd0, wrc[1]}, 32'd1);

        // Random waits against the reference LFSR and memory model.
        nrd = 0;
        for (int n = 0; n < 50; n++) begin
            c = 1'($urandom_range(0, 1));
            a = $urandom;
            d = $urandom;
            if (n < 8) a = {a[31:6], 6'(n * 4)};
            txn(2, c, a, d, dly, lf);
            chk($sformatf("r%0d_delay", n), dly, 32'(lf[1:0]) + 32'd1);
            if (dly < 1 || dly > 4) begin
                total++; bad++;
                $display("FAIL r%0d_range: got=%0d want=1..4", n, dly);
            end
            if (c) begin
                m_mem[a[5:2]] = d;
            end else begin
                nrd++;
                chk($sformatf("r%0d_rdata", n), rdata[2], m_mem[a[5:2]]);
            end
        end
        chk("rnd_sum", 32'(wrc[2]) + 32'(rdc[2]), 32'd50);
        chk("rnd_rdcnt", {16'd0, rdc[2]}, nrd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/slave_mem_responder.md
SLAVE_MEM_RESPONDER -- requirements
Module: slave_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 16, meaning the number of 32-bit words (power of two, 2..256).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning the fixed wait states before ack (0..15).
REQ-003 SHALL have parameter RANDOM_WAIT, default 0, meaning that when 1 the wait comes from the LFSR instead of WAIT_CYCLES.
REQ-004 SHALL have parameter LFSR_SEED, default 8'hA5, meaning the nonzero LFSR reset value.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-007 SHALL have port slave_req, input, 1 bit, the transaction request from the crossbar.
REQ-008 SHALL have port slave_addr, input, 32 bits, the byte address.
REQ-009 SHALL have port slave_cmd, input, 1 bit, where 0 means read and 1 means write.
REQ-010 SHALL have port slave_wdata, input, 32 bits, the write data, valid with the address.
REQ-011 SHALL have port slave_ack, output, 1 bit, a one-cycle acceptance pulse.
REQ-012 SHALL have port slave_rdata, output, 32 bits, the read data, valid in the cycle after ack.
REQ-013 SHALL have port busy, output, 1 bit, high while the FSM is not in IDLE.
REQ-014 SHALL have port wr_cnt, output, 16 bits, the count of completed writes, saturating.
REQ-015 SHALL have port rd_cnt, output, 16 bits, the count of completed reads, saturating.

Function
REQ-016 FSM SHALL have the states IDLE, WAIT and ACK, fully registered, with no combinational path from any input to slave_ack.
REQ-017 In IDLE with slave_req=1, the block SHALL latch addr, cmd and wdata, then go to ACK if the wait is 0, else load wcnt=wait-1 and go to WAIT.
REQ-018 In WAIT with slave_req=1, the block SHALL go to ACK when wcnt=0, else decrement wcnt.
REQ-019 In WAIT with slave_req=0 (master withdrew), the block SHALL go to IDLE with no ack, no memory write, no rdata change and no counter change.
REQ-020 ACK SHALL last exactly one cycle with slave_ack=1, then return to IDLE unconditionally.
REQ-021 A still-high slave_req after ACK SHALL be treated as a new transaction sampled in IDLE, so back-to-back transactions have at least one idle cycle between acks.
REQ-022 Ack SHALL rise 1+wait cycles after the edge at which IDLE first samples slave_req=1.
REQ-023 Word index SHALL be slave_addr[log2(MEM_DEPTH)+1:2]; bits [1:0] and all upper bits SHALL be ignored, so addresses alias modulo MEM_DEPTH*4.
REQ-024 On a write, mem[index] SHALL be updated with the latched wdata at the edge ending ACK.
REQ-025 On a read, slave_rdata SHALL load mem[index] at the edge ending ACK and hold until the next completed read; writes SHALL NOT change slave_rdata.
REQ-026 wr_cnt or rd_cnt SHALL increment at the edge ending ACK and hold at 16'hFFFF with no wrap.
REQ-027 The LFSR SHALL be 8 bits, Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advancing every cycle.
REQ-028 With RANDOM_WAIT=1, the wait SHALL equal lfsr[1:0] as sampled in IDLE at acceptance (range 0..3).
REQ-029 Input changes after acceptance SHALL have no effect, because only the latched fields are used.

Reset
REQ-030 While reset=1 at a rising edge, the block SHALL go to IDLE with slave_ack=0, slave_rdata=0, busy=0, wr_cnt=0, rd_cnt=0, wcnt=0, lfsr=LFSR_SEED and all mem words=0.
REQ-031 Reset asserted in WAIT or ACK SHALL abort the transaction: no memory write and no counter update at that edge.
REQ-032 The first transaction SHALL be sampled no earlier than the first edge with reset=0.

Verification
REQ-033 Scenario (WAIT_CYCLES=1): write addr=0x8, wdata=0x1234_5678, req held -> ack high exactly 2 cycles after req sampled, for 1 cycle; wr_cnt=1; rdata unchanged (0).
REQ-034 Scenario: read addr=0x8 after the write above -> ack one pulse; rdata=0x1234_5678 in the cycle after ack; rd_cnt=1.
REQ-035 Scenario (MEM_DEPTH=16): write 0xDEAD_BEEF to addr=0x4, then read addr=0x44 and addr=0x8000_0004 -> both return 0xDEAD_BEEF (aliasing).
REQ-036 Scenario (WAIT_CYCLES=3): req dropped after 1 WAIT cycle -> no ack, mem unchanged, counters unchanged, busy=0 on the next cycle.
REQ-037 Scenario: reset asserted during ACK of a write of 0xFFFF_FFFF to addr 0 -> ack=0 next cycle, mem[0]=0, wr_cnt=0; a subsequent read of addr 0 returns 0.
REQ-038 Scenario (RANDOM_WAIT=1, seed 8'hA5): 50 back-to-back random transactions checked against a reference model -> every ack delay is within 1..4 cycles, all read data match, and wr_cnt+rd_cnt=50.
